// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle datapath: FSM states, opcode and
// funct encodings, ALU control codes and the instruction-legality helpers.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
      ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, TRAP
   } mc_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
      case (funct)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic op_legal(input logic [5:0] opcode, input logic [5:0] funct);
      case (opcode)
         OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                          (funct == FN_OR)  || (funct == FN_SLT);
         OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file with two combinational read ports and one synchronous write
// port; register 0 always reads zero and ignores writes.
module mc_regfile #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(NREGS)-1:0] waddr,
   input  logic [XLEN-1:0]          wdata,
   input  logic [$clog2(NREGS)-1:0] raddr1,
   input  logic [$clog2(NREGS)-1:0] raddr2,
   output logic [XLEN-1:0]          rdata1,
   output logic [XLEN-1:0]          rdata2
);

   logic [XLEN-1:0] regs_q [NREGS];

   // Contents are deliberately left unreset so the array maps onto plain storage.
   always_ff @(posedge clk) begin
      if (we && (waddr != '0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: one FSM sequences fetch, decode, execute,
// memory access and write-back over a single shared memory port.
module multicycle_datapath
   import mc_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ready,
   input  logic [XLEN-1:0] mem_rdata,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic            trap
);

   localparam int AW = $clog2(NREGS);

   mc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;

   logic [5:0]      opcode, funct;
   logic [4:0]      rs, rt, rd;
   logic [XLEN-1:0] sign_imm, alu_result, rf_rd1, rf_rd2, rf_wdata;
   logic [2:0]      alu_ctrl;
   logic [AW-1:0]   rf_waddr;
   logic            rf_we, regs_ok, instr_ok;
   logic            unused_shamt;

   assign opcode       = ir_q[31:26];
   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign funct        = ir_q[5:0];
   assign sign_imm     = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
   assign unused_shamt = ^ir_q[10:6];

   mc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk    (clk),
      .we     (rf_we),
      .waddr  (rf_waddr),
      .wdata  (rf_wdata),
      .raddr1 (rs[AW-1:0]),
      .raddr2 (rt[AW-1:0]),
      .rdata1 (rf_rd1),
      .rdata2 (rf_rd2)
   );

   // Jumps carry no register fields, so only the other formats check specifiers.
   always_comb begin
      regs_ok = (int'(rs) < NREGS) && (int'(rt) < NREGS);
      if (opcode == OP_RTYPE) begin
         regs_ok = regs_ok && (int'(rd) < NREGS);
      end
      instr_ok = op_legal(opcode, funct) && ((opcode == OP_J) || regs_ok);
   end

   always_comb begin
      alu_ctrl = funct_to_alu(funct);
      case (alu_ctrl)
         ALU_ADD: alu_result = a_q + b_q;
         ALU_SUB: alu_result = a_q - b_q;
         ALU_AND: alu_result = a_q & b_q;
         ALU_OR:  alu_result = a_q | b_q;
         ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         default: alu_result = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      mdr_d     = mdr_q;
      rf_we     = 1'b0;
      rf_waddr  = rt[AW-1:0];
      rf_wdata  = alu_out_q;
      case (state_q)
         FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata[31:0];
               pc_d    = pc_q + XLEN'(4);
               state_d = DECODE;
            end
         end
         DECODE: begin
            a_d       = rf_rd1;
            b_d       = rf_rd2;
            alu_out_d = pc_q + (sign_imm << 2);
            if (!instr_ok) begin
               state_d = TRAP;
            end else begin
               case (opcode)
                  OP_LW, OP_SW: state_d = MEMADR;
                  OP_RTYPE:     state_d = EXEC;
                  OP_ADDI:      state_d = ADDIEX;
                  OP_BEQ:       state_d = BRANCH;
                  OP_J:         state_d = JUMP;
                  default:      state_d = TRAP;
               endcase
            end
         end
         MEMADR: begin
            alu_out_d = a_q + sign_imm;
            state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            if (mem_ready) begin
               mdr_d   = mem_rdata;
               state_d = MEMWB;
            end
         end
         MEMWR: begin
            if (mem_ready) begin
               state_d = FETCH;
            end
         end
         MEMWB: begin
            rf_we    = 1'b1;
            rf_wdata = mdr_q;
            state_d  = FETCH;
         end
         EXEC: begin
            alu_out_d = alu_result;
            state_d   = ALUWB;
         end
         ALUWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd[AW-1:0];
            state_d  = FETCH;
         end
         ADDIEX: begin
            alu_out_d = a_q + sign_imm;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            rf_we   = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            if (a_q == b_q) begin
               pc_d = alu_out_q;
            end
            state_d = FETCH;
         end
         JUMP: begin
            pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
            state_d = FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         mdr_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         mdr_q     <= mdr_d;
      end
   end

   // The request is gated by reset directly so it drops the instant reset asserts.
   assign mem_req   = reset && ((state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR));
   assign mem_we    = (state_q == MEMWR);
   assign mem_addr  = (state_q == FETCH) ? pc_q : alu_out_q;
   assign mem_wdata = b_q;
   assign pc        = pc_q;
   assign trap      = (state_q == TRAP);

   always_comb begin
      retire = 1'b0;
      case (state_q)
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: retire = 1'b1;
         MEMWR:   retire = mem_ready;
         default: retire = 1'b0;
      endcase
   end

endmodule
